// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: ops, ALU controls, FSM states.
package muldiv_pkg;

  localparam int DW = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_ITER   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO with MTHI/MTLO write ports; a sequencer commit wins over MT writes.
module hilo_regs #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hi_we_i,
  input  logic          lo_we_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          commit_i,
  input  logic [DW-1:0] commit_hi_i,
  input  logic [DW-1:0] commit_lo_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_i) begin
      hi_d = commit_hi_i;
      lo_d = commit_lo_i;
    end else begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer borrowing the EX-stage ALU; fixed 37-cycle latency (1 for divide-by-zero).
// Signed ops run on magnitudes and fix the signs afterwards; EX stalls while busy is high.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  input  logic [DW-1:0] alu_out,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    alu_ctrl,
  output logic          alu_own,
  output logic          busy,
  output logic          done,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_t state_q, state_d;

  logic          div_q, div_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          lz_q, lz_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] acc_hi_q, acc_hi_d;
  logic [DW-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          commit;
  logic [DW-1:0] commit_hi, commit_lo;

  logic          div_by_zero;
  logic [DW-1:0] rem_shift;
  logic          mul_carry;
  logic          div_take;
  logic          fix_hi_en;
  logic [DW-1:0] hi_fixed;

  assign div_by_zero = op_is_div(op) && (rt_val == '0);
  // Restoring step: subtract succeeds if the shifted-out bit was set or no borrow occurs.
  assign rem_shift   = {acc_hi_q[DW-2:0], acc_lo_q[DW-1]};
  assign div_take    = acc_hi_q[DW-1] | ~(rem_shift < b_q);
  assign mul_carry   = alu_out < acc_hi_q;
  assign fix_hi_en   = div_q ? sa_q : (sa_q ^ sb_q);
  assign hi_fixed    = fix_hi_en ? alu_out : acc_hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = div_by_zero ? ST_DONE : ST_NEG_A;
      ST_NEG_A:  state_d = ST_NEG_B;
      ST_NEG_B:  state_d = ST_ITER;
      ST_ITER:   if (cnt_q == CNT_LAST) state_d = ST_FIX_LO;
      ST_FIX_LO: state_d = ST_FIX_HI;
      ST_FIX_HI: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_ctrl = ALU_ADD;
    alu_own  = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    case (state_q)
      ST_NEG_A: begin
        alu_own  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_in2  = a_q;
      end
      ST_NEG_B: begin
        alu_own  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_in2  = b_q;
      end
      ST_ITER: begin
        alu_own = 1'b1;
        if (div_q) begin
          alu_ctrl = ALU_SUB;
          alu_in1  = rem_shift;
          alu_in2  = b_q;
        end else begin
          alu_ctrl = ALU_ADD;
          alu_in1  = acc_hi_q;
          alu_in2  = acc_lo_q[0] ? b_q : '0;
        end
      end
      ST_FIX_LO: begin
        alu_own  = 1'b1;
        alu_ctrl = ALU_SUB;
        alu_in2  = acc_lo_q;
      end
      ST_FIX_HI: begin
        alu_own = 1'b1;
        if (div_q) begin
          alu_ctrl = ALU_SUB;
          alu_in2  = acc_hi_q;
        end else begin
          alu_ctrl = ALU_ADD;
          alu_in1  = ~acc_hi_q;
          alu_in2  = {{(DW-1){1'b0}}, lz_q};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    lz_d      = lz_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    commit    = 1'b0;
    commit_hi = '0;
    commit_lo = '0;
    case (state_q)
      ST_IDLE: begin
        if (start && div_by_zero) begin
          commit    = 1'b1;
          commit_hi = rs_val;
          commit_lo = '1;
        end else if (start) begin
          div_d = op_is_div(op);
          a_d   = rs_val;
          b_d   = rt_val;
          sa_d  = op_is_signed(op) & rs_val[DW-1];
          sb_d  = op_is_signed(op) & rt_val[DW-1];
        end
      end
      ST_NEG_A: if (sa_q) a_d = alu_out;
      ST_NEG_B: begin
        if (sb_q) b_d = alu_out;
        acc_hi_d = '0;
        acc_lo_d = a_q;
        cnt_d    = '0;
      end
      ST_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_hi_d = div_take ? alu_out : rem_shift;
          acc_lo_d = {acc_lo_q[DW-2:0], div_take};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_carry, alu_out, acc_lo_q[DW-1:1]};
        end
      end
      ST_FIX_LO: begin
        lz_d = (acc_lo_q == '0);
        if (sa_q ^ sb_q) acc_lo_d = alu_out;
      end
      ST_FIX_HI: begin
        acc_hi_d  = hi_fixed;
        commit    = 1'b1;
        commit_hi = hi_fixed;
        commit_lo = acc_lo_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      lz_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      lz_q     <= lz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  hilo_regs #(.DW(DW)) u_hilo (
    .clk_i       (clk),
    .rst_i       (rst),
    .hi_we_i     (hi_we),
    .lo_we_i     (lo_we),
    .wdata_i     (wdata),
    .commit_i    (commit),
    .commit_hi_i (commit_hi),
    .commit_lo_i (commit_lo),
    .hi_o        (hi),
    .lo_o        (lo)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] alu_out, alu_in1, alu_in2;
  logic [3:0]  alu_ctrl;
  logic        alu_own, busy, done;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign alu_out = (alu_ctrl == 4'b0001) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

  muldiv_seq #(.DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_out  (alu_out),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_own  (alu_own),
    .busy     (busy),
    .done     (done),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 1: raise start mid-op; mode 2: MTLO mid-ITER and on the commit edge
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input int mode, input string tag);
    int c;
    int own_bad;
    own_bad = 0;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start = 1'b0;
    c = 1;
    while (!done && c < 60) begin
      if (alu_own !== ((lat > 1) && (c <= 36))) own_bad++;
      if (c == 1 && lat > 1) check({tag, "_neg_a_ctrl"}, {28'd0, alu_ctrl}, 32'd1);
      if (mode == 1) begin
        start = (c >= 5 && c <= 7);
        op = 2'b01; rs_val = 32'd5; rt_val = 32'd5;
      end
      if (mode == 2) begin
        if (c == 10) begin lo_we = 1'b1; wdata = 32'hAAAA5555; end
        if (c == 11) begin check({tag, "_mtlo_mid"}, lo, 32'hAAAA5555); lo_we = 1'b0; end
        if (c == 36) begin lo_we = 1'b1; wdata = 32'h12345678; end
      end
      tick();
      c++;
    end
    lo_we = 1'b0;
    start = 1'b0;
    check({tag, "_latency"}, c, lat);
    check({tag, "_own_window"}, own_bad, 0);
    check({tag, "_own_at_done"}, {31'd0, alu_own}, 32'd0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    tick();
    check({tag, "_idle_busy"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_own", {31'd0, alu_own}, 32'd0);
    check("rst_hilo", hi | lo, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_alu_ins", alu_in1 | alu_in2, 32'd0);
    check("idle_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 37, 0, "multu_max");
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 37, 0, "mult_neg3x5");
    do_op(2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 37, 0, "mult_min");
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 37, 0, "div_neg7_2");
    do_op(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 37, 0, "divu_100_7");
    do_op(2'b10, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1, 0, "div_zero");
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 37, 0, "div_ovf");
    do_op(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 37, 1, "start_busy");
    do_op(2'b01, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 37, 2, "mtlo");

    hi_we = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hCAFEF00D);
    check("mthi_lo_kept", lo, 32'h0000002A);

    // Abort at ITER cnt=10 (12 cycles after NEG_A)
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_flags", {29'd0, busy, alu_own, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_op(2'b00, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA, 37, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
